// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: fixed A-over-B priority with a starvation
// counter that forces a B grant after STARVE_LIMIT consecutive losses.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [63:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [63:0] b_rdata,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_read_data
);

  localparam int unsigned CW = 4;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   b_wait;
  logic            b_starved_c;
  logic            grant_b_c;

  // B wins when A is silent or B has lost STARVE_LIMIT arbitrations in a row
  assign b_starved_c = (b_wait == CW'(STARVE_LIMIT));
  assign grant_b_c   = b_req && (b_starved_c || !a_req);

  // Read data comes straight from the registered memory output
  assign a_rdata = mem_read_data;
  assign b_rdata = mem_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      b_wait         <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
    end else begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state <= ISSUE;
            if (grant_b_c) begin
              b_ack          <= 1'b1;
              mem_address    <= b_addr;
              mem_write_data <= b_wdata;
              mem_write      <= b_we;
              mem_read       <= !b_we;
              b_wait         <= '0;
            end else begin
              a_ack          <= 1'b1;
              mem_address    <= a_addr;
              mem_write_data <= a_wdata;
              mem_write      <= a_we;
              mem_read       <= !a_we;
              if (b_req && !b_starved_c) begin
                b_wait <= b_wait + CW'(1);
              end
            end
          end
        end
        ISSUE: begin
          // The ack registers still identify the owner of the access in flight
          state    <= IDLE;
          a_rvalid <= a_ack && mem_read;
          b_rvalid <= b_ack && mem_read;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small registered memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [63:0] a_rdata, b_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct { bit who; bit we; logic [63:0] addr; logic [63:0] data; } grant_t;
  typedef struct { bit who; logic [63:0] data; } rd_t;

  grant_t gq[$];
  rd_t    rq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     first_a, first_b;
  bit     mon_en = 1'b0;
  bit     prev_a_rd = 1'b0, prev_b_rd = 1'b0, rst_at_edge = 1'b0;
  logic [63:0] mem_arr [0:31];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Registered memory: word-indexed, read data valid the cycle after the read edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
    if (mem_write) mem_arr[mem_address[7:3]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem_arr[mem_address[7:3]];
  end

  // Monitor: pops grants on ack, predicts rvalid from the previous cycle's read ack
  always @(negedge clk) begin
    if (mon_en) begin
      grant_t g;
      rd_t    r;
      check_eq("a_rvalid", 64'(a_rvalid), 64'(prev_a_rd && !rst_at_edge));
      check_eq("b_rvalid", 64'(b_rvalid), 64'(prev_b_rd && !rst_at_edge));
      if (a_rvalid || b_rvalid) begin
        if (rq.size() == 0) check_eq("unexpected_rvalid", 64'(1), 64'(0));
        else begin
          r = rq.pop_front();
          check_eq("rvalid_owner", 64'(b_rvalid), 64'(r.who));
          check_eq("rdata", r.who ? b_rdata : a_rdata, r.data);
        end
      end
      if (a_ack || b_ack) begin
        check_eq("dual_ack", 64'(a_ack && b_ack), 64'(0));
        if (gq.size() == 0) check_eq("unexpected_ack", 64'(1), 64'(0));
        else begin
          g = gq.pop_front();
          check_eq("ack_owner", 64'(b_ack), 64'(g.who));
          check_eq("mem_write", 64'(mem_write), 64'(g.we));
          check_eq("mem_read", 64'(mem_read), 64'(!g.we));
          check_eq("mem_address", mem_address, g.addr);
          if (g.we) check_eq("mem_write_data", mem_write_data, g.data);
        end
      end else begin
        check_eq("strobes_without_ack", 64'({mem_write, mem_read}), 64'(0));
      end
      prev_a_rd = a_ack && mem_read;
      prev_b_rd = b_ack && mem_read;
    end
  end

  // Hold each requester's req until it has been acked the requested number of times
  task automatic run(input int na, input int nb, input bit awe, input bit bwe,
                     input logic [63:0] aa, input logic [63:0] ba,
                     input logic [63:0] ad, input logic [63:0] bd);
    a_we = awe; b_we = bwe; a_addr = aa; b_addr = ba; a_wdata = ad; b_wdata = bd;
    a_req = (na > 0); b_req = (nb > 0);
    first_a = -1; first_b = -1;
    for (int t = 0; t < 60 && (a_req || b_req); t++) begin
      @(negedge clk);
      if (a_ack && a_req) begin
        if (first_a < 0) first_a = cyc;
        na--;
        if (na == 0) a_req = 1'b0;
      end
      if (b_ack && b_req) begin
        if (first_b < 0) first_b = cyc;
        nb--;
        if (nb == 0) b_req = 1'b0;
      end
    end
    check_eq("req_timeout", 64'({a_req, b_req}), 64'(0));
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] bw_snap;
    for (int i = 0; i < 32; i++) mem_arr[i] = '0;
    rst = 1'b1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_address", mem_address, 64'(0));
    check_eq("rst_mem_write_data", mem_write_data, 64'(0));
    check_eq("rst_outputs", 64'({mem_write, mem_read, a_ack, b_ack, a_rvalid, b_rvalid}), 64'(0));
    check_eq("rst_b_wait", 64'(dut.b_wait), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // A write then read back
    gq.push_back('{who: 1'b0, we: 1'b1, addr: 64'h10, data: 64'hDEADBEEF});
    run(1, 0, 1'b1, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF, 64'h0);
    gq.push_back('{who: 1'b0, we: 1'b0, addr: 64'h10, data: 64'h0});
    rq.push_back('{who: 1'b0, data: 64'hDEADBEEF});
    run(1, 0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h0);

    // Simultaneous request: A first, B two cycles later
    gq.push_back('{who: 1'b0, we: 1'b1, addr: 64'h60, data: 64'h1});
    gq.push_back('{who: 1'b1, we: 1'b1, addr: 64'h68, data: 64'h2});
    run(1, 1, 1'b1, 1'b1, 64'h60, 64'h68, 64'h1, 64'h2);
    check_eq("simul_b_gap", 64'(first_b - first_a), 64'(2));
    check_eq("simul_b_wait", 64'(dut.b_wait), 64'(0));

    // Starvation: four A grants, then B, then A resumes
    for (int i = 0; i < 4; i++)
      gq.push_back('{who: 1'b0, we: 1'b1, addr: 64'h40, data: 64'hAAAA});
    gq.push_back('{who: 1'b1, we: 1'b1, addr: 64'h48, data: 64'hBBBB});
    for (int i = 0; i < 2; i++)
      gq.push_back('{who: 1'b0, we: 1'b1, addr: 64'h40, data: 64'hAAAA});
    run(6, 1, 1'b1, 1'b1, 64'h40, 64'h48, 64'hAAAA, 64'hBBBB);
    check_eq("starve_b_gap", 64'(first_b - first_a), 64'(8));
    check_eq("starve_b_wait", 64'(dut.b_wait), 64'(0));

    // B write then read routed to B only
    gq.push_back('{who: 1'b1, we: 1'b1, addr: 64'h20, data: 64'h1234});
    run(0, 1, 1'b0, 1'b1, 64'h0, 64'h20, 64'h0, 64'h1234);
    gq.push_back('{who: 1'b1, we: 1'b0, addr: 64'h20, data: 64'h0});
    rq.push_back('{who: 1'b1, data: 64'h1234});
    run(0, 1, 1'b0, 1'b0, 64'h0, 64'h20, 64'h0, 64'h0);

    // Reset during an A read ISSUE
    gq.push_back('{who: 1'b0, we: 1'b0, addr: 64'h10, data: 64'h0});
    a_we = 1'b0; a_addr = 64'h10; a_req = 1'b1;
    for (int t = 0; t < 10 && !a_ack; t++) @(negedge clk);
    check_eq("rst_issue_ack", 64'(a_ack), 64'(1));
    a_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rst_issue_state", 64'(dut.state), 64'(0));
    check_eq("rst_issue_strobes", 64'({mem_write, mem_read, a_ack, b_ack}), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Idle: nothing issued, b_wait untouched
    bw_snap = 64'(dut.b_wait);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_quiet", 64'({mem_write, mem_read, a_ack, b_ack}), 64'(0));
    end
    check_eq("idle_b_wait", 64'(dut.b_wait), bw_snap);

    check_eq("grant_queue_drained", 64'(gq.size()), 64'(0));
    check_eq("read_queue_drained", 64'(rq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, the number of consecutive lost arbitrations after which B wins (range 1..15).
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: a_req  input  1  request from requester A (pipeline memory stage); held until acked.
REQ-005 SHALL have port: a_we  input  1  for A, 1 = write, 0 = read.
REQ-006 SHALL have port: a_addr  input  64  address from A.
REQ-007 SHALL have port: a_wdata  input  64  write data from A.
REQ-008 SHALL have port: a_ack  output  1  one-cycle pulse: A's command is being issued.
REQ-009 SHALL have port: a_rvalid  output  1  one-cycle pulse: a_rdata holds A's read result.
REQ-010 SHALL have port: a_rdata  output  64  read data returned to A.
REQ-011 SHALL have ports b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata, identical to the A ports, for requester B (loader/debug).
REQ-012 SHALL have port: mem_address  output  64  address to the data memory.
REQ-013 SHALL have port: mem_write_data  output  64  write data to the data memory.
REQ-014 SHALL have port: mem_write  output  1  memory write strobe.
REQ-015 SHALL have port: mem_read  output  1  memory read strobe.
REQ-016 SHALL have port: mem_read_data  input  64  data from the memory, registered, valid the cycle after a read edge.

Function
REQ-017 SHALL be an FSM with two states, IDLE and ISSUE; requests are sampled only at an edge ending an IDLE cycle.
REQ-018 SHALL, at an IDLE edge with any req high, select a winner, go to ISSUE, and register the winner's addr/wdata onto mem_address/mem_write_data.
REQ-019 SHALL, at that edge, set mem_write = winner_we and mem_read = !winner_we; otherwise both SHALL be 0.
REQ-020 SHALL, in ISSUE, assert exactly one of a_ack/b_ack for that one cycle; the memory performs the access at the edge ending ISSUE.
REQ-021 SHALL always return from ISSUE to IDLE; the requester must drop req in the cycle after ack, and req values sampled during ISSUE are ignored.
REQ-022 SHALL, in the IDLE cycle after a read ISSUE, pulse the owner's rvalid for one cycle; x_rdata = mem_read_data combinationally, and the non-owner's rvalid stays 0.
REQ-023 SHALL set no rvalid after a write.
REQ-024 SHALL sustain one access per 2 cycles, with read latency of 2 edges from the granting edge.
REQ-025 SHALL use priority A > B, with a 4-bit starve counter b_wait.
REQ-026 SHALL increment b_wait, saturating at STARVE_LIMIT, at an IDLE edge where A is granted while b_req=1.
REQ-027 SHALL grant B at an IDLE edge where b_req=1 and b_wait==STARVE_LIMIT, even if a_req=1.
REQ-028 SHALL clear b_wait to 0 on any B grant.
REQ-029 SHALL leave b_wait unchanged at an IDLE edge with b_req=0.
REQ-030 SHALL stay in IDLE with mem strobes 0 when neither requester asks.
REQ-031 SHALL pass the full 64-bit address unmodified; memory word selection belongs to the memory.

Reset
REQ-032 SHALL, at an edge with rst=1, set state=IDLE, b_wait=0, mem_write=0, mem_read=0, mem_address=0, mem_write_data=0, and all ack/rvalid to 0.
REQ-033 SHALL, if rst rises during ISSUE, let the memory still perform the strobe present at that edge, and SHALL produce no rvalid for it.
REQ-034 SHALL take rst priority over all requests, with no grant at a reset edge.

Verification
REQ-035 SHALL test a single A write then read: A writes addr 0x10, data 0xDEADBEEF; then A reads 0x10 -> a_ack in the cycle after each grant, a_rvalid 2 edges after the read grant with a_rdata=0xDEADBEEF.
REQ-036 SHALL test a simultaneous request: a_req=b_req=1 from IDLE with b_wait=0 -> A acked first and B acked on the next IDLE edge (B grant 2 cycles later).
REQ-037 SHALL test starvation: A requests continuously and B holds req with STARVE_LIMIT=4 -> A granted 4 times, then B granted on the 5th arbitration, and b_wait returns to 0.
REQ-038 SHALL test B read routing: B reads addr 0x20 holding 0x1234 -> b_rvalid=1 with b_rdata=0x1234, and a_rvalid stays 0.
REQ-039 SHALL test reset mid-ISSUE: rst asserted during an A read ISSUE -> no a_rvalid, state IDLE, mem strobes 0 after the reset edge.
REQ-040 SHALL test idle: no requests for 10 cycles -> mem_write=mem_read=0, no acks, and b_wait unchanged.
